// File: rtl/sipo_collect_pkg.sv
// Shared sizing for the serial-in/parallel-out frame collector.
// Holds the default lane count, the half-word width and the
// counter width derived from the lane count.
package sipo_collect_pkg;

  localparam int SIPO_PE_NUM     = 8;
  localparam int SIPO_DATA_WIDTH = 16;
  localparam int SIPO_CNT_W      = $clog2(SIPO_PE_NUM);

  // Counter width for an arbitrary lane count, never narrower than one bit
  function automatic int sipoCntWidth(input int peNum);
    return (peNum > 1) ? $clog2(peNum) : 1;
  endfunction

endpackage

// File: rtl/sipo_collect.sv
// Serial-in to parallel-out collector.
// Gathers PE_NUM serial words into a frame and presents the frame to the
// PE array through a valid/ready pair. The frame sits in its own output
// register, so the next frame can be collected while this one waits.
module sipo_collect
  import sipo_collect_pkg::*;
#(
  parameter int PE_NUM     = SIPO_PE_NUM,
  parameter int DATA_WIDTH = SIPO_DATA_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             s_in_v,
  input  logic [DATA_WIDTH*2-1:0]          s_in,
  output logic                             s_in_rdy,
  output logic                             p_out_v,
  output logic [PE_NUM*DATA_WIDTH*2-1:0]   p_out,
  input  logic                             p_out_rdy
);

  localparam int W     = DATA_WIDTH * 2;
  localparam int FW    = PE_NUM * W;
  localparam int CNT_W = sipoCntWidth(PE_NUM);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PE_NUM - 1);

  // The final lane is never stored; it goes straight into the output frame
  logic [W-1:0]     lane_q [PE_NUM-1];
  logic [W-1:0]     lane_d [PE_NUM-1];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pOutV_q, pOutV_d;
  logic [FW-1:0]    pOut_q, pOut_d;

  logic lastWord;
  logic wordXfer;
  logic frameDone;

  // Ready depends only on the collect position and the output handshake,
  // never on s_in_v; stall only when the completing word has nowhere to go
  always_comb begin
    lastWord  = (cnt_q == LAST_IDX);
    s_in_rdy  = !rst && !(lastWord && pOutV_q && !p_out_rdy);
    wordXfer  = s_in_v && s_in_rdy;
    frameDone = wordXfer && lastWord;
  end

  // Next-state: collect lanes, wrap the counter and load the output frame
  always_comb begin
    cnt_d   = cnt_q;
    pOutV_d = pOutV_q;
    pOut_d  = pOut_q;
    for (int i = 0; i < PE_NUM - 1; i++) begin
      lane_d[i] = lane_q[i];
    end

    if (wordXfer) begin
      if (lastWord) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
        for (int i = 0; i < PE_NUM - 1; i++) begin
          if (cnt_q == CNT_W'(i)) begin
            lane_d[i] = s_in;
          end
        end
      end
    end

    if (frameDone) begin
      for (int i = 0; i < PE_NUM - 1; i++) begin
        pOut_d[i*W +: W] = lane_q[i];
      end
      pOut_d[(PE_NUM-1)*W +: W] = s_in;
      pOutV_d = 1'b1;
    end else if (pOutV_q && p_out_rdy) begin
      pOutV_d = 1'b0;
    end
  end

  // State registers; reset discards any partial frame and the held frame
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      pOutV_q <= 1'b0;
      pOut_q  <= '0;
      for (int i = 0; i < PE_NUM - 1; i++) begin
        lane_q[i] <= '0;
      end
    end else begin
      cnt_q   <= cnt_d;
      pOutV_q <= pOutV_d;
      pOut_q  <= pOut_d;
      for (int i = 0; i < PE_NUM - 1; i++) begin
        lane_q[i] <= lane_d[i];
      end
    end
  end

  assign p_out_v = pOutV_q;
  assign p_out   = pOut_q;

endmodule

// File: tb/tb_sipo_collect.sv
// Self-checking bench for sipo_collect with four 32-bit lanes.
// Inputs are driven just after each rising edge; ready is sampled on the
// falling edge and the registered outputs just after the next rising edge.
module tb_sipo_collect;

  localparam int PE = 4;
  localparam int DW = 16;
  localparam int W  = DW * 2;
  localparam int FW = PE * W;

  logic          clk;
  logic          rst;
  logic          s_in_v;
  logic [W-1:0]  s_in;
  logic          s_in_rdy;
  logic          p_out_v;
  logic [FW-1:0] p_out;
  logic          p_out_rdy;

  sipo_collect #(.PE_NUM(PE), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_in_v    (s_in_v),
    .s_in      (s_in),
    .s_in_rdy  (s_in_rdy),
    .p_out_v   (p_out_v),
    .p_out     (p_out),
    .p_out_rdy (p_out_rdy)
  );

  // Free-running 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic          v;
    logic [W-1:0]  d;
    logic          prdy;
    logic          expRdy;
    logic          expV;
    logic [FW-1:0] expP;
  } vec_t;

  vec_t vecs[6];

  int checks = 0;
  int errors = 0;

  // Reference model: a queue of words collected so far and the held frame
  logic [W-1:0]  mWords[$];
  logic          mValid;
  logic [FW-1:0] mFrame;
  logic          lastRdy;

  task automatic checkOutput(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic modelReady(input logic prdy);
    return !((mWords.size() == PE - 1) && mValid && !prdy);
  endfunction

  task automatic modelClock(input logic v, input logic [W-1:0] d, input logic prdy);
    logic acc;
    logic done;
    acc  = v && modelReady(prdy);
    done = 1'b0;
    if (acc) begin
      mWords.push_back(d);
      if (mWords.size() == PE) begin
        for (int j = 0; j < PE; j++) mFrame[j*W +: W] = mWords[j];
        mWords.delete();
        done = 1'b1;
      end
    end
    if (done) mValid = 1'b1;
    else if (mValid && prdy) mValid = 1'b0;
  endtask

  function automatic logic [FW-1:0] mkFrame(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [W-1:0] c, input logic [W-1:0] d);
    return {d, c, b, a};
  endfunction

  // One clock of traffic, checked against the model on both sides of the edge
  task automatic applyStimulus(input logic v, input logic [W-1:0] d, input logic prdy);
    s_in_v    = v;
    s_in      = d;
    p_out_rdy = prdy;
    #4;
    lastRdy = s_in_rdy;
    checkOutput("s_in_rdy", FW'(lastRdy), FW'(modelReady(prdy)));
    @(posedge clk);
    #1;
    modelClock(v, d, prdy);
    checkOutput("p_out_v", FW'(p_out_v), FW'(mValid));
    checkOutput("p_out", p_out, mFrame);
  endtask

  // Hold reset with valid high; ready must be low and outputs cleared
  task automatic applyReset(input int n);
    for (int i = 0; i < n; i++) begin
      rst       = 1'b1;
      s_in_v    = 1'b1;
      s_in      = W'($urandom);
      p_out_rdy = 1'b0;
      #4;
      checkOutput("rst_rdy", FW'(s_in_rdy), '0);
      @(posedge clk);
      #1;
      checkOutput("rst_pv", FW'(p_out_v), '0);
      checkOutput("rst_pout", p_out, '0);
    end
    rst = 1'b0;
    mWords.delete();
    mValid = 1'b0;
    mFrame = '0;
  endtask

  initial begin
    int frames;
    int drops;
    int gap;
    logic [W-1:0] gw[4];

    rst = 1'b1; s_in_v = 1'b0; s_in = '0; p_out_rdy = 1'b0;
    mValid = 1'b0; mFrame = '0; lastRdy = 1'b0;
    @(posedge clk);
    #1;

    vecs[0] = '{1'b1, 32'h11111111, 1'b1, 1'b1, 1'b0, '0};
    vecs[1] = '{1'b1, 32'h22222222, 1'b1, 1'b1, 1'b0, '0};
    vecs[2] = '{1'b1, 32'h33333333, 1'b1, 1'b1, 1'b0, '0};
    vecs[3] = '{1'b1, 32'h44444444, 1'b1, 1'b1, 1'b1, 128'h44444444_33333333_22222222_11111111};
    vecs[4] = '{1'b0, 32'hdeadbeef, 1'b1, 1'b1, 1'b0, 128'h44444444_33333333_22222222_11111111};
    vecs[5] = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 128'h44444444_33333333_22222222_11111111};

    // Reset with valid held high
    applyReset(3);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("post_rst_rdy", FW'(lastRdy), FW'(1));
    checkOutput("post_rst_pv", FW'(p_out_v), '0);

    // Basic frame from the vector table
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].v, vecs[i].d, vecs[i].prdy);
      checkOutput($sformatf("vec%0d_rdy", i), FW'(lastRdy), FW'(vecs[i].expRdy));
      checkOutput($sformatf("vec%0d_pv", i), FW'(p_out_v), FW'(vecs[i].expV));
      checkOutput($sformatf("vec%0d_pout", i), p_out, vecs[i].expP);
    end

    // Streaming 1..12 with the consumer always ready
    frames = 0;
    drops  = 0;
    for (int k = 1; k <= 12; k++) begin
      applyStimulus(1'b1, W'(k), 1'b1);
      if (!lastRdy) drops++;
      if (p_out_v) frames++;
    end
    checkOutput("stream_frames", FW'(frames), FW'(3));
    checkOutput("stream_drops", FW'(drops), '0);
    checkOutput("stream_last", p_out, mkFrame(32'd9, 32'd10, 32'd11, 32'd12));
    applyStimulus(1'b0, '0, 1'b1);

    // Backpressure: first frame held, stall only on the completing word
    for (int k = 1; k <= 7; k++) applyStimulus(1'b1, W'(k), 1'b0);
    checkOutput("bp_held", p_out, mkFrame(32'd1, 32'd2, 32'd3, 32'd4));
    applyStimulus(1'b1, W'(8), 1'b0);
    checkOutput("bp_stall_rdy", FW'(lastRdy), '0);
    checkOutput("bp_stall_pout", p_out, mkFrame(32'd1, 32'd2, 32'd3, 32'd4));
    applyStimulus(1'b1, W'(8), 1'b1);
    checkOutput("bp_release_rdy", FW'(lastRdy), FW'(1));
    checkOutput("bp_release_pv", FW'(p_out_v), FW'(1));
    checkOutput("bp_release_pout", p_out, mkFrame(32'd5, 32'd6, 32'd7, 32'd8));
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("bp_drained_pv", FW'(p_out_v), '0);

    // Gapped input: nothing emitted until the fourth word lands
    for (int k = 0; k < 4; k++) begin
      gw[k] = W'($urandom);
      gap = $urandom_range(0, 5);
      for (int g = 0; g < gap; g++) begin
        applyStimulus(1'b0, W'($urandom), 1'b1);
        checkOutput("gap_idle_pv", FW'(p_out_v), '0);
      end
      applyStimulus(1'b1, gw[k], 1'b1);
      if (k < 3) checkOutput("gap_early_pv", FW'(p_out_v), '0);
    end
    checkOutput("gap_pv", FW'(p_out_v), FW'(1));
    checkOutput("gap_pout", p_out, mkFrame(gw[0], gw[1], gw[2], gw[3]));

    // Reset mid-frame discards the partial frame
    applyStimulus(1'b1, 32'hAAAA0001, 1'b1);
    applyStimulus(1'b1, 32'hAAAA0002, 1'b1);
    applyReset(1);
    applyStimulus(1'b1, 32'h0000000A, 1'b1);
    applyStimulus(1'b1, 32'h0000000B, 1'b1);
    applyStimulus(1'b1, 32'h0000000C, 1'b1);
    applyStimulus(1'b1, 32'h0000000D, 1'b1);
    checkOutput("midrst_pv", FW'(p_out_v), FW'(1));
    checkOutput("midrst_pout", p_out, mkFrame(32'hA, 32'hB, 32'hC, 32'hD));

    // Random traffic on both sides against the model
    for (int c = 0; c < 400; c++) begin
      applyStimulus(($urandom_range(0, 9) < 7), W'($urandom), ($urandom_range(0, 9) < 5));
    end
    applyStimulus(1'b0, '0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
